// File: rtl/overture_encoder.sv
// OVERTURE opcode encoder: encodes requests into opcode bytes, buffers them in a FIFO and
// writes them to sequential program addresses. Define OVERTURE_ENC_CHECK_EN to reject illegal requests.
module overture_encoder #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [1:0]            KIND,
  input  logic [5:0]            VALUE,
  input  logic [2:0]            SRC,
  input  logic [2:0]            DST,
  output logic                  WR_EN,
  input  logic                  WR_READY,
  output logic [ADDR_WIDTH-1:0] WR_ADDR,
  output logic [7:0]            WR_DATA,
  output logic                  DONE,
  input  logic                  CLEAR,
  output logic                  ERR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [PTR_W:0]        count;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_addr, acc_cnt;
  logic [7:0]            mem [DEPTH];
  logic [7:0]            enc_p0;
  logic                  accept, push, pop, illegal;

  function automatic logic [7:0] encode(input logic [1:0] kind, input logic [5:0] value,
                                        input logic [2:0] src, input logic [2:0] dst);
    case (kind)
      2'd0:    return {2'b00, value};
      2'd1:    return {2'b01, 3'b000, dst};
      2'd2:    return {2'b10, src, dst};
      default: return {2'b11, 3'b000, dst};
    endcase
  endfunction

  assign enc_p0 = encode(KIND, VALUE, SRC, DST);
  assign accept = IN_VALID & IN_READY;
  assign push   = accept & ~illegal;
  assign pop    = WR_EN & WR_READY;

`ifdef OVERTURE_ENC_CHECK_EN
  logic err_q;
  assign illegal = ((KIND == 2'd1) && (DST > 3'd5)) ||
                   ((KIND == 2'd2) && ((SRC == 3'd7) || (DST == 3'd7)));
  assign ERR     = err_q;
`else
  assign illegal = 1'b0;
  assign ERR     = 1'b0;
`endif

  always_comb begin
    IN_READY = 1'b0;
    WR_EN    = 1'b0;
    DONE     = 1'b0;
    case (state)
      S_LOAD: begin
        IN_READY = (count < FULL_CNT);
        WR_EN    = (count != '0);
      end
      S_DRAIN: WR_EN = (count != '0);
      S_DONE:  DONE  = 1'b1;
      default: ;
    endcase
  end

  // The last address is only ever written after the final push, so DONE is reached from DRAIN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:  if (push && (acc_cnt == LAST_ADDR)) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && (wr_addr == LAST_ADDR))  state_nxt = S_DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || CLEAR) begin
      state   <= S_LOAD;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_addr <= '0;
      acc_cnt <= '0;
`ifdef OVERTURE_ENC_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (wr_addr != LAST_ADDR) wr_addr <= wr_addr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
`ifdef OVERTURE_ENC_CHECK_EN
      if (accept && illegal) err_q <= 1'b1;
`endif
    end
  end

  // FIFO storage carries data only; a discarded push lands in a slot the pointers never expose.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_p0;
  end

  assign WR_ADDR = wr_addr;
  assign WR_DATA = (count != '0) ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_overture_encoder.sv
// Bench for overture_encoder: directed vector table, hand-written corner sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_overture_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int NADDR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, in_valid, wr_ready, clear;
  logic [1:0]    kind;
  logic [5:0]    value;
  logic [2:0]    src, dst;
  logic          in_ready, wr_en, done, err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  overture_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .KIND(kind), .VALUE(value), .SRC(src), .DST(dst),
    .WR_EN(wr_en), .WR_READY(wr_ready), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .DONE(done), .CLEAR(clear), .ERR(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of buffered bytes plus address / capacity bookkeeping.
  logic [7:0] q[$];
  int  m_addr, m_pushed;
  bit  m_done, m_drain, m_err, m_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_enc(input int k, input int v, input int s, input int d);
    int r;
    case (k)
      0:       r = v;
      1:       r = 64 + d;
      2:       r = 128 + 8 * s + d;
      default: r = 192 + d;
    endcase
    return r[7:0];
  endfunction

  function automatic bit ref_illegal(input int k, input int s, input int d);
`ifdef OVERTURE_ENC_CHECK_EN
    return (k == 1 && d > 5) || (k == 2 && (s == 7 || d == 7));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr = 0; m_pushed = 0; m_done = 0; m_drain = 0; m_err = 0;
  endtask

  task automatic model_check();
    bit ir, we;
    if (!m_valid) return;
    ir = !m_done && !m_drain && (q.size() < DEPTH);
    we = !m_done && (q.size() > 0);
    chk("model_in_ready", 32'(in_ready), 32'(ir));
    chk("model_wr_en",    32'(wr_en),    32'(we));
    chk("model_wr_addr",  32'(wr_addr),  32'(m_addr));
    chk("model_done",     32'(done),     32'(m_done));
    chk("model_err",      32'(err),      32'(m_err));
    if (q.size() > 0) chk("model_wr_data", 32'(wr_data), 32'(q[0]));
  endtask

  task automatic model_update();
    bit ir, we;
    if (rst) begin model_reset(); m_valid = 1'b1; return; end
    if (!m_valid) return;
    if (clear) begin model_reset(); return; end
    ir = !m_done && !m_drain && (q.size() < DEPTH);
    we = !m_done && (q.size() > 0);
    if (we && wr_ready) begin
      void'(q.pop_front());
      if (m_addr == NADDR - 1) m_done = 1'b1;
      else m_addr++;
    end
    if (in_valid && ir) begin
      if (ref_illegal(int'(kind), int'(src), int'(dst))) m_err = 1'b1;
      else begin
        q.push_back(ref_enc(int'(kind), int'(value), int'(src), int'(dst)));
        m_pushed++;
        if (m_pushed == NADDR) m_drain = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic pulse_clear();
    in_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic req(input logic [1:0] k, input logic [5:0] v, input logic [2:0] s, input logic [2:0] d);
    kind = k; value = v; src = s; dst = d;
  endtask

  typedef struct {
    logic [1:0] k; logic [5:0] v; logic [2:0] s; logic [2:0] d;
    logic [7:0] exp_data; logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [4];
  int   n_acc;

  initial begin
    vecs[0] = '{k: 2'd0, v: 6'h2A, s: 3'd0, d: 3'd0, exp_data: 8'h2A, exp_addr: 3'd0};
    vecs[1] = '{k: 2'd2, v: 6'h00, s: 3'd3, d: 3'd5, exp_data: 8'h9D, exp_addr: 3'd1};
    vecs[2] = '{k: 2'd1, v: 6'h3F, s: 3'd7, d: 3'd4, exp_data: 8'h44, exp_addr: 3'd2};
    vecs[3] = '{k: 2'd3, v: 6'h15, s: 3'd2, d: 3'd7, exp_data: 8'hC7, exp_addr: 3'd3};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    req(2'd0, 6'd0, 3'd0, 3'd0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  32'(wr_data),  32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);

    // Single requests: each write shows up the cycle after acceptance.
    for (int i = 0; i < 4; i++) begin
      req(vecs[i].k, vecs[i].v, vecs[i].s, vecs[i].d);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("vec_wr_en",   32'(wr_en),   32'd1);
      chk("vec_wr_data", 32'(wr_data), 32'(vecs[i].exp_data));
      chk("vec_wr_addr", 32'(wr_addr), 32'(vecs[i].exp_addr));
      tick();
      chk("vec_drained", 32'(wr_en), 32'd0);
    end

    // Backpressure: FIFO fills after DEPTH accepts, then drains in order.
    pulse_clear();
    wr_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req(2'd0, 6'(16 + n_acc), 3'd0, 3'd0);
      if (in_ready) n_acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepts",  32'(n_acc),    32'(DEPTH));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_wr_en",    32'(wr_en),    32'd1);
    chk("bp_held",     32'(wr_data),  32'h10);
    wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("bp_data", 32'(wr_data), 32'(16 + i));
      chk("bp_addr", 32'(wr_addr), 32'(i));
      tick();
    end
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    chk("bp_empty",      32'(wr_en),    32'd0);

    // Fill the whole address space, reach DONE, then restart with CLEAR.
    pulse_clear();
    in_valid = 1'b1;
    for (int i = 0; i < NADDR; i++) begin
      req(2'd0, 6'(i), 3'd0, 3'd0);
      chk("fill_ready", 32'(in_ready), 32'd1);
      tick();
      chk("fill_data", 32'(wr_data), 32'(i));
      chk("fill_addr", 32'(wr_addr), 32'(i));
    end
    in_valid = 1'b0;
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("done_flag",     32'(done),     32'd1);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_wr_en",    32'(wr_en),    32'd0);
    pulse_clear();
    chk("clr_done", 32'(done), 32'd0);
    req(2'd0, 6'h15, 3'd0, 3'd0); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("clr_addr", 32'(wr_addr), 32'd0);
    chk("clr_data", 32'(wr_data), 32'h15);
    tick();

    // Illegal CALCULATION op followed by a legal request.
    pulse_clear();
    req(2'd1, 6'd0, 3'd0, 3'd6); in_valid = 1'b1;
    tick();
`ifdef OVERTURE_ENC_CHECK_EN
    chk("ill_no_write", 32'(wr_en), 32'd0);
    chk("ill_err",      32'(err),   32'd1);
`else
    chk("ill_data", 32'(wr_data), 32'h46);
    chk("ill_addr", 32'(wr_addr), 32'd0);
`endif
    req(2'd0, 6'd1, 3'd0, 3'd0);
    tick();
    in_valid = 1'b0;
    chk("ill_next_data", 32'(wr_data), 32'h01);
`ifdef OVERTURE_ENC_CHECK_EN
    chk("ill_next_addr", 32'(wr_addr), 32'd0);
    chk("ill_err_sticky", 32'(err), 32'd1);
`else
    chk("ill_next_addr", 32'(wr_addr), 32'd1);
    chk("ill_err_zero",  32'(err),     32'd0);
`endif
    tick();

    // CLEAR with bytes buffered and a request pending.
    pulse_clear();
    wr_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req(2'd0, 6'(32 + i), 3'd0, 3'd0);
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("cb_wr_en",    32'(wr_en),    32'd0);
    chk("cb_addr",     32'(wr_addr),  32'd0);
    chk("cb_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("cb_nothing", 32'(wr_en), 32'd0);
    wr_ready = 1'b1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      req(2'($urandom), 6'($urandom), 3'($urandom), 3'($urandom));
      wr_ready = ($urandom_range(0, 9) < 7);
      clear    = m_done ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/overture_encoder.md
# overture_encoder

Program-side counterpart of the OVERTURE opcode decoder. Accepts instruction requests (class plus fields) over a valid/ready handshake and encodes each into the 8-bit OVERTURE opcode byte. Encoded bytes are buffered in a small FIFO and written sequentially into program memory through an auto-incrementing address counter. It sits between the program loader/debug front end and program RAM.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 8: program memory address width.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- IN_VALID  input  1  request present.
- IN_READY  output  1  request accepted this cycle when high with IN_VALID.
- KIND  input  2  0=IMMEDIATE, 1=CALCULATION, 2=COPY, 3=CONDITION.
- VALUE  input  6  immediate value; IMMEDIATE only.
- SRC  input  3  COPY source register.
- DST  input  3  COPY destination; ALU op for CALCULATION; condition code for CONDITION.
- WR_EN  output  1  memory write request.
- WR_READY  input  1  memory accepts write this cycle.
- WR_ADDR  output  ADDR_WIDTH  write address.
- WR_DATA  output  8  encoded opcode.
- DONE  output  1  sticky; last address written.
- CLEAR  input  1  restart at address 0; empties FIFO; clears DONE/ERR.
- ERR  output  1  sticky illegal-request flag (see Configuration).

## Operation
- Encoding (bits 7:6 = KIND):
  - IMMEDIATE: {2'b00, VALUE}.
  - CALCULATION: {2'b01, 3'b000, DST}.
  - COPY: {2'b10, SRC, DST}.
  - CONDITION: {2'b11, 3'b000, DST}.
- Unused fields are ignored, never OR'd in.
- FIFO: DEPTH entries, occupancy counter 0..DEPTH, read/write pointers wrap modulo DEPTH.
  - Push on IN_VALID & IN_READY.
  - Pop on WR_EN & WR_READY.
  - Push and pop in the same cycle: occupancy unchanged, both pointers advance.
- State machine:
  - LOAD: IN_READY = (count < DEPTH); WR_EN = (count != 0).
  - DRAIN: entered when a request is accepted and ADDR_WIDTH-bit input capacity is exhausted, i.e. accepted-total reaches 2^ADDR_WIDTH. IN_READY = 0; WR_EN = (count != 0).
  - DONE: entered on the pop that writes address 2^ADDR_WIDTH-1. DONE = 1; IN_READY = 0; WR_EN = 0. Left only via rst or CLEAR.
- Address counter: WR_ADDR = address of FIFO head; increments by 1 on each pop. Never wraps; DONE stops it at 2^ADDR_WIDTH-1.
- CLEAR (any state): count, pointers and address go to 0; DONE, ERR go to 0; state goes to LOAD. A push or pop in the same cycle is discarded.
- WR_DATA is driven from the FIFO head and is stable while WR_EN & !WR_READY.

## Timing
- Reset values:
  - IN_READY=1, WR_EN=0, WR_ADDR=0, WR_DATA=0, DONE=0, ERR=0.
  - FIFO empty, state LOAD.
- Latency: a request accepted at edge N appears on WR_EN/WR_DATA in cycle N+1 (after edge N). There is no combinational path from IN_* to WR_*.
- Throughput: 1 byte/cycle sustained when WR_READY stays high.
- Backpressure: with WR_READY low, the FIFO fills after DEPTH accepts and IN_READY drops in the same cycle that count reaches DEPTH.
- IN_READY depends only on registered state; it is not combinational from WR_READY. A full FIFO therefore does not accept even while popping.
- rst has priority over CLEAR. rst mid-burst discards all buffered bytes without writing them.

## Configuration
- OVERTURE_ENC_CHECK_EN defined: illegal requests are accepted (handshake completes) but not pushed, and ERR is set sticky. Illegal requests are:
  - CALCULATION with DST > 5 (ops 0-5 only).
  - COPY with SRC == 7 or DST == 7.
- OVERTURE_ENC_CHECK_EN undefined: all requests are encoded as-is and pushed; ERR is tied 0.

## Test plan
- After reset, single requests with WR_READY=1:
  - IMMEDIATE VALUE=0x2A → WR_DATA=0x2A at WR_ADDR=0.
  - COPY SRC=3 DST=5 → 0x9D at 1.
  - CALCULATION DST=4 → 0x44 at 2.
  - CONDITION DST=7 → 0xC7 at 3.
  - Each write appears exactly one cycle after acceptance.
- WR_READY=0, DEPTH=4, IN_VALID held high:
  - Exactly 4 accepts, then IN_READY=0 and WR_EN=1 with WR_DATA held at the first byte.
  - Raise WR_READY → 4 writes in order, after which IN_READY returns to 1.
- ADDR_WIDTH=3, 8 IMMEDIATE requests VALUE=0..7 → addresses 0..7 written in order, then DONE=1, IN_READY=0, WR_EN=0.
  - Pulse CLEAR → DONE=0; the next request is written to address 0.
- With OVERTURE_ENC_CHECK_EN: CALCULATION DST=6, then IMMEDIATE VALUE=1 → ERR=1, and only 0x01 is written, at address 0.
  - Without the macro: 0x46 is written at 0 and 0x01 at 1; ERR stays 0.
- CLEAR asserted with 3 bytes buffered and IN_VALID high → the next cycle shows WR_EN=0, address 0 and no byte accepted from that cycle.
